// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   calc_addr_w : memory index width derived from DEPTH
//   fifo_err_t  : sticky error flag pair, also used by the subsystem scoreboard
package fifo_pkg;

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH simple dual-port register array.
//   clk       : clock
//   we_i      : write strobe
//   waddr_i   : write index
//   wdata_i   : write data
//   raddr_i   : read index (asynchronous read)
//   rdata_o   : read data
// Contents are deliberately not reset.
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = calc_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow flags and an
// optional first-word-fall-through read path.
//   clk, reset           : clock, synchronous active-high reset
//   write_en, data_in    : push request and data
//   read_en, data_out    : pop request and read data
//   empty, full          : occupancy 0 / DEPTH
//   almost_full/_empty   : count >= AF_THRESH / count <= AE_THRESH
//   count                : occupancy 0..DEPTH
//   clr_err              : clears sticky flags (a same-cycle set wins)
//   overflow, underflow  : sticky error flags
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = calc_addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_T  = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T  = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] MAX_T = PTR_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 0) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_THRESH must be within 0..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  fifo_err_t         err_q, err_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc, rd_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // Acceptance uses pre-edge state only: no bypass through a same-cycle pop/push.
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    err_d    = err_q;
    if (clr_err)           err_d = '0;
    if (write_en && full)  err_d.overflow  = 1'b1;
    if (read_en && empty)  err_d.underflow = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; zero while empty so stale memory never leaks.
    assign data_out = empty ? '0 : mem_rdata;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (reset)       rd_data_q <= '0;
      else if (rd_acc) rd_data_q <= mem_rdata;
    end

    assign data_out = rd_data_q;
  end

  a_count_max: assert property (@(posedge clk) disable iff (reset) count <= MAX_T);
  a_full_empty: assert property (@(posedge clk) disable iff (reset) !(full && empty));
  a_wr_inc: assert property (@(posedge clk) disable iff (reset)
    wr_acc |=> (wr_ptr_q == $past(wr_ptr_q) + PTR_W'(1)));
  a_rd_inc: assert property (@(posedge clk) disable iff (reset)
    rd_acc |=> (rd_ptr_q == $past(rd_ptr_q) + PTR_W'(1)));
  a_wr_stable: assert property (@(posedge clk) disable iff (reset) !wr_acc |=> $stable(wr_ptr_q));
  a_rd_stable: assert property (@(posedge clk) disable iff (reset) !rd_acc |=> $stable(rd_ptr_q));

  c_full:     cover property (@(posedge clk) disable iff (reset) full);
  c_empty:    cover property (@(posedge clk) disable iff (reset) empty);
  c_rw_full:  cover property (@(posedge clk) disable iff (reset) write_en && read_en && full);
  c_rw_empty: cover property (@(posedge clk) disable iff (reset) write_en && read_en && empty);
  c_rw_mid:   cover property (@(posedge clk) disable iff (reset) wr_acc && rd_acc);
  c_ovf:      cover property (@(posedge clk) disable iff (reset) write_en && full);
  c_unf:      cover property (@(posedge clk) disable iff (reset) read_en && empty);
  c_wr_wrap:  cover property (@(posedge clk) disable iff (reset) wr_acc && (wr_ptr_q == '1));
  c_rd_wrap:  cover property (@(posedge clk) disable iff (reset) rd_acc && (rd_ptr_q == '1));

endmodule
